// File: rtl/bcd_to_bin_conv.sv
// Sequential packed-BCD to binary converter: one digit per clock, MSB first,
// acc = acc*10 + digit. Invalid nibbles force a zero result with err set.
module bcd_to_bin_conv #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state, state_nxt;
  logic [4*DIGITS-1:0] sreg;
  logic [BIN_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic                bad;
  logic [3:0]          dig;

  assign dig = sreg[4*DIGITS-1 -: 4];

  // acc*10 + d as (acc<<3)+(acc<<1)+d, widened by 4 bits then truncated
  function automatic logic [BIN_W-1:0] mac10(input logic [BIN_W-1:0] a,
                                             input logic [3:0]       d);
    logic [BIN_W+3:0] w;
    w = ({4'b0000, a} << 3) + ({4'b0000, a} << 1) + {{BIN_W{1'b0}}, d};
    return w[BIN_W-1:0];
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (cnt == CNT_W'(DIGITS - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      bad     <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            cnt <= '0;
            bad <= 1'b0;
          end
        end
        CONV: begin
          acc <= mac10(acc, dig);
          cnt <= cnt + CNT_W'(1);
          if (dig > 4'd9) bad <= 1'b1;
        end
        DONE: begin
          bin_out <= bad ? '0 : acc;
          err     <= bad;
        end
        default: ;
      endcase
    end
  end

  // Digit shift register is pure data; only loaded in IDLE and consumed in CONV
  always_ff @(posedge clk) begin
    if (state == IDLE && start) sreg <= bcd_in;
    else if (state == CONV)     sreg <= sreg << 4;
  end

endmodule
